// File: rtl/memory_stage_pkg.sv
// Shared pipeline definitions for the memory stage: FSM states, timeout
// default, counter width and small address helpers.
package memory_stage_pkg;

  // Default number of ACCESS cycles to wait for mem_ack before aborting.
  localparam int unsigned ACK_TIMEOUT_DEF = 16;

  // Width of the ACCESS-cycle counter (covers timeouts up to 255).
  localparam int unsigned CNT_W = 8;

  // Bus FSM: IDLE decodes the instruction, ACCESS owns the data bus.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mstate_e;

  // Word accesses only: the two low address bits must be zero.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/memory_stage_regmw.sv
// M/W pipeline register. A bubble clears the control bits and holds the data
// fields. A load captures the M-stage instruction; read data is captured only
// when rd_we_i is set, so stores and ALU ops leave ReadDataW untouched.
module RegMW (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic        rd_we_i,
  input  logic        pcsrc_i,
  input  logic        regwrite_i,
  input  logic        memtoreg_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] rdata_i,
  input  logic [3:0]  wa3_i,
  output logic        pcsrc_o,
  output logic        regwrite_o,
  output logic        memtoreg_o,
  output logic [31:0] alu_o,
  output logic [31:0] rdata_o,
  output logic [3:0]  wa3_o
);

  logic        pcsrc_q;
  logic        regwrite_q;
  logic        memtoreg_q;
  logic [31:0] alu_q;
  logic [31:0] rdata_q;
  logic [3:0]  wa3_q;

  // Pipeline register update: bubble has priority over load, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      alu_q      <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      wa3_q      <= 4'h0;
    end else if (bubble_i) begin
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else if (load_i) begin
      pcsrc_q    <= pcsrc_i;
      regwrite_q <= regwrite_i;
      memtoreg_q <= memtoreg_i;
      alu_q      <= alu_i;
      wa3_q      <= wa3_i;
      if (rd_we_i) begin
        rdata_q <= rdata_i;
      end else begin
        rdata_q <= rdata_q;
      end
    end else begin
      pcsrc_q    <= pcsrc_q;
      regwrite_q <= regwrite_q;
      memtoreg_q <= memtoreg_q;
    end
  end

  assign pcsrc_o    = pcsrc_q;
  assign regwrite_o = regwrite_q;
  assign memtoreg_o = memtoreg_q;
  assign alu_o      = alu_q;
  assign rdata_o    = rdata_q;
  assign wa3_o      = wa3_q;

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues word loads/stores on a registered request
// bus, stalls the upstream pipeline while the bus is busy, aborts on a
// missing acknowledge, and feeds the M/W register.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WA3M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic [31:0] ALUResultMFB,
  output logic        PCSrcW,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [3:0]  WA3W,
  output logic        AlignErr,
  output logic        BusErr
);

  // Counter value seen in the last ACCESS cycle allowed before abort.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  mstate_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic             align_err_q;
  logic             bus_err_q;

  logic mem_op_s;
  logic stall_s;
  logic start_s;
  logic misalign_s;
  logic timeout_s;
  logic mw_load_s;
  logic mw_bubble_s;
  logic mw_rd_we_s;

  assign mem_op_s = MemWriteM | MemtoRegM;
  assign cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Per-cycle decode of stall, bus start/abort and what the M/W register does.
  always_comb begin
    stall_s     = 1'b0;
    start_s     = 1'b0;
    misalign_s  = 1'b0;
    timeout_s   = 1'b0;
    mw_load_s   = 1'b0;
    mw_bubble_s = 1'b0;
    mw_rd_we_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op_s) begin
          mw_bubble_s = 1'b1;
          if (is_word_aligned(ALUResultM)) begin
            stall_s = 1'b1;
            start_s = 1'b1;
          end else begin
            misalign_s = 1'b1;
          end
        end else begin
          mw_load_s = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          // Ack wins even in the final allowed cycle.
          mw_load_s  = 1'b1;
          mw_rd_we_s = ~MemWriteM;
        end else if (cnt_q >= TMO_LAST) begin
          timeout_s   = 1'b1;
          mw_bubble_s = 1'b1;
        end else begin
          stall_s     = 1'b1;
          mw_bubble_s = 1'b1;
        end
      end
      default: begin
        mw_bubble_s = 1'b1;
      end
    endcase
  end

  // Bus FSM with registered request outputs, cycle counter and error pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      align_err_q <= misalign_s;
      bus_err_q   <= timeout_s;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start_s) begin
            state_q     <= ACCESS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= MemWriteM;
            mem_addr_q  <= ALUResultM;
            mem_wdata_q <= WriteDataM;
          end else begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_ack || timeout_s) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  RegMW u_regmw (
    .clk        (clk),
    .reset      (reset),
    .load_i     (mw_load_s),
    .bubble_i   (mw_bubble_s),
    .rd_we_i    (mw_rd_we_s),
    .pcsrc_i    (PCSrcM),
    .regwrite_i (RegWriteM),
    .memtoreg_i (MemtoRegM),
    .alu_i      (ALUResultM),
    .rdata_i    (mem_rdata),
    .wa3_i      (WA3M),
    .pcsrc_o    (PCSrcW),
    .regwrite_o (RegWriteW),
    .memtoreg_o (MemtoRegW),
    .alu_o      (ALUOutW),
    .rdata_o    (ReadDataW),
    .wa3_o      (WA3W)
  );

  assign StallM       = stall_s;
  assign ALUResultMFB = ALUResultM;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign AlignErr     = align_err_q;
  assign BusErr       = bus_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a W-stage scoreboard.
module tb_memory_stage;

  logic        clk;
  logic        reset;
  logic        PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  WA3M;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        StallM;
  logic [31:0] ALUResultMFB;
  logic        PCSrcW, RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [3:0]  WA3W;
  logic        AlignErr, BusErr;

  typedef struct packed {
    logic        pcsrc;
    logic        regw;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [3:0]  wa3;
  } wexp_t;

  wexp_t       w_model;
  wexp_t       sb[$];
  int          checks;
  int          errors;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;

  memory_stage #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .StallM(StallM), .ALUResultMFB(ALUResultMFB),
    .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WA3W(WA3W),
    .AlignErr(AlignErr), .BusErr(BusErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic pc, input logic rw, input logic mw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa);
    PCSrcM = pc; RegWriteM = rw; MemWriteM = mw; MemtoRegM = m2r;
    ALUResultM = alu; WriteDataM = wd; WA3M = wa;
  endtask

  // kind: 0 = bubble, 1 = load without read data, 2 = load with read data
  task automatic step(input string tag, input logic exp_stall, input int kind,
                      input logic exp_req, input logic exp_we,
                      input logic exp_aerr, input logic exp_berr);
    wexp_t w;
    @(negedge clk);
    chk({tag, ".stall"}, {31'd0, StallM}, {31'd0, exp_stall});
    chk({tag, ".fwd"}, ALUResultMFB, ALUResultM);
    w = w_model;
    if (kind == 0) begin
      w.pcsrc = 1'b0; w.regw = 1'b0; w.m2r = 1'b0;
    end else begin
      w.pcsrc = PCSrcM; w.regw = RegWriteM; w.m2r = MemtoRegM;
      w.alu = ALUResultM; w.wa3 = WA3M;
      if (kind == 2) w.rd = mem_rdata;
    end
    w_model = w;
    sb.push_back(w);
    @(posedge clk);
    #1;
    w = sb.pop_front();
    chk({tag, ".PCSrcW"}, {31'd0, PCSrcW}, {31'd0, w.pcsrc});
    chk({tag, ".RegWriteW"}, {31'd0, RegWriteW}, {31'd0, w.regw});
    chk({tag, ".MemtoRegW"}, {31'd0, MemtoRegW}, {31'd0, w.m2r});
    chk({tag, ".ALUOutW"}, ALUOutW, w.alu);
    chk({tag, ".ReadDataW"}, ReadDataW, w.rd);
    chk({tag, ".WA3W"}, {28'd0, WA3W}, {28'd0, w.wa3});
    chk({tag, ".mem_req"}, {31'd0, mem_req}, {31'd0, exp_req});
    chk({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, exp_we});
    chk({tag, ".AlignErr"}, {31'd0, AlignErr}, {31'd0, exp_aerr});
    chk({tag, ".BusErr"}, {31'd0, BusErr}, {31'd0, exp_berr});
    if (exp_req) begin
      chk({tag, ".mem_addr"}, mem_addr, exp_addr);
      chk({tag, ".mem_wdata"}, mem_wdata, exp_wdata);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, ".mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, ".mem_addr"}, mem_addr, 32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, ".ctrlW"}, {29'd0, PCSrcW, RegWriteW, MemtoRegW}, 32'd0);
    chk({tag, ".ReadDataW"}, ReadDataW, 32'd0);
    chk({tag, ".ALUOutW"}, ALUOutW, 32'd0);
    chk({tag, ".WA3W"}, {28'd0, WA3W}, 32'd0);
    chk({tag, ".errs"}, {30'd0, AlignErr, BusErr}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    w_model = '0;
    exp_addr = 32'd0;
    exp_wdata = 32'd0;
    reset = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #3;
    chk_all_zero("reset");
    chk("reset.stall", {31'd0, StallM}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // ALU op: one-cycle passthrough
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'd3);
    step("alu1", 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Aligned load, ack on first ACCESS cycle
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'h1111_2222, 4'd5);
    exp_addr = 32'h0000_0100; exp_wdata = 32'h1111_2222;
    step("ld_idle", 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step("ld_ack", 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b0; mem_rdata = 32'h0BAD_F00D;

    // Store, ack after three waiting cycles (ack coincides with the last allowed cycle)
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h5A5A_5A5A, 4'd0);
    exp_addr = 32'h0000_0104; exp_wdata = 32'h5A5A_5A5A;
    step("st_idle", 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("st_wait", 1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    mem_ack = 1'b1;
    step("st_ack", 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Ack while IDLE with a non-memory op must be ignored
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 32'h0, 4'd9);
    step("idle_ack", 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b0;

    // Misaligned load: no request, one AlignErr pulse
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 4'd6);
    step("mis_ld", 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'd7);
    step("alu2", 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load with no ack: abort after four ACCESS cycles
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h3333_4444, 4'd8);
    exp_addr = 32'h0000_0200; exp_wdata = 32'h3333_4444;
    step("to_idle", 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("to_wait", 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("to_abort", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0030, 32'h0, 4'd2);
    step("alu3", 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-ACCESS, then a late ack after release
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h5555_6666, 4'd4);
    exp_addr = 32'h0000_0300; exp_wdata = 32'h5555_6666;
    step("rst_ld", 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h7777_8888;
    w_model = '0;
    step("late_ack", 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b0;
    step("after", 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter: ACK_TIMEOUT, 16, max ACCESS cycles to wait for mem_ack before abort (range 2..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 PCSrcM, RegWriteM, MemWriteM, MemtoRegM  input  1 each  M-stage controls from the E/M pipeline register.
REQ-005 ALUResultM  input  32  memory address or ALU result.
REQ-006 WriteDataM  input  32  store data.
REQ-007 WA3M  input  4  destination register.
REQ-008 mem_req  output  1  data-memory request, registered.
REQ-009 mem_we  output  1  write enable for the request, registered.
REQ-010 mem_addr, mem_wdata  output  32 each  request address/data, registered.
REQ-011 mem_ack  input  1  one-cycle completion from data memory.
REQ-012 mem_rdata  input  32  load data, valid only when mem_ack=1.
REQ-013 StallM  output  1  holds Fetch/Decode/E/M registers while high (combinational).
REQ-014 ALUResultMFB  output  32  forwarding copy of ALUResultM (combinational passthrough).
REQ-015 PCSrcW, RegWriteW, MemtoRegW  output  1 each  M/W register controls.
REQ-016 ReadDataW, ALUOutW  output  32 each  M/W register data.
REQ-017 WA3W  output  4  M/W register destination.
REQ-018 AlignErr, BusErr  output  1 each  one-cycle error pulses, registered.

Function
REQ-019 Memory op SHALL be MemWriteM=1 (store) or MemtoRegM=1 (load); store takes precedence if both set.
REQ-020 FSM states SHALL be IDLE and ACCESS only.
REQ-021 IDLE, memory op, ALUResultM[1:0]=00: StallM=1; next edge -> ACCESS with mem_req=1, mem_we=MemWriteM, mem_addr=ALUResultM, mem_wdata=WriteDataM.
REQ-022 IDLE, memory op, ALUResultM[1:0]!=00: no request, StallM=0, AlignErr pulses next cycle, M/W loads a bubble.
REQ-023 ACCESS without mem_ack: StallM=1, request outputs stable, timeout counter increments.
REQ-024 ACCESS with mem_ack: StallM=0; next edge -> IDLE, mem_req=0, M/W loads instruction with ReadDataW=mem_rdata (loads) or unchanged data (stores).
REQ-025 Counter reaching ACK_TIMEOUT in ACCESS without ack: StallM=0, BusErr pulses, M/W loads a bubble, -> IDLE, mem_req=0.
REQ-026 Ack arriving in the same cycle as timeout SHALL count as success (no BusErr).
REQ-027 mem_ack in IDLE SHALL be ignored.
REQ-028 Non-memory instruction in IDLE: StallM=0; M/W loads PCSrcM, RegWriteM, MemtoRegM, ALUResultM, WA3M next edge (1-cycle latency).
REQ-029 Bubble SHALL mean PCSrcW=RegWriteW=MemtoRegW=0; data fields don't-care but deterministic (hold).
REQ-030 While StallM=1, M/W SHALL load a bubble each edge.
REQ-031 Minimum memory-op residency SHALL be 2 cycles (IDLE detect + ACCESS with ack); non-memory 1 cycle.
REQ-032 ALUResultMFB SHALL equal ALUResultM every cycle irrespective of state.
REQ-033 Stores SHALL never write the register file: RegWriteW passes as given by RegWriteM (decoder guarantees 0).

Reset
REQ-034 reset low SHALL immediately force IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=mem_wdata=0, AlignErr=BusErr=0, all M/W outputs 0.
REQ-035 Reset asserted mid-ACCESS SHALL drop mem_req asynchronously; a late mem_ack after reset release SHALL be ignored.

Structure
REQ-036 State enum (IDLE, ACCESS) and ACK_TIMEOUT default SHALL live in the shared pipeline package.
REQ-037 The M/W register SHALL be a separate sub-module RegMW with load and bubble inputs; FSM and bus logic remain in memory_stage.

Verification
REQ-038 ALU op (RegWriteM=1, ALUResultM=0x0000_0010, WA3M=3) -> StallM=0, next cycle RegWriteW=1, ALUOutW=0x10, WA3W=3.
REQ-039 Load addr 0x100, ack on first ACCESS cycle with mem_rdata=0xDEAD_BEEF -> StallM high 1 cycle, ReadDataW=0xDEADBEEF, MemtoRegW=1, 2 cycles total.
REQ-040 Store addr 0x104 data 0x5A5A_5A5A, ack after 3 ACCESS cycles -> mem_we=1, addr/data stable 3 cycles, StallM high 4 cycles, RegWriteW=0.
REQ-041 Load addr 0x102 -> no mem_req, AlignErr one pulse, RegWriteW=0, StallM never high.
REQ-042 Load, no ack, ACK_TIMEOUT=4 -> mem_req high 4 cycles then low, BusErr one pulse, bubble in M/W, next instruction accepted.
REQ-043 reset low during ACCESS, mem_ack asserted after release -> mem_req=0 immediately, all outputs 0, late ack ignored, FSM stays IDLE.
